// File: rtl/demux_pkg.sv
// Shared constants and types for the crossbar input-side demux router.
package demux_pkg;

    localparam int NUM_PORTS  = 7;
    localparam int DATA_WIDTH = 256;
    localparam int VALID_BIT  = DATA_WIDTH - 1;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_YNEG  = 1;
    localparam int PORT_YPOS  = 2;
    localparam int PORT_XPOS  = 3;
    localparam int PORT_XNEG  = 4;
    localparam int PORT_ZPOS  = 5;
    localparam int PORT_ZNEG  = 6;

    typedef logic [NUM_PORTS-1:0] port_mask_t;

    // Ports still owed a copy after this cycle's deliveries.
    function automatic port_mask_t remaining_after(input port_mask_t rem, input port_mask_t avail);
        return rem & ~avail;
    endfunction

endpackage

// File: rtl/demux_router_if.sv
// Packet stream bundle: one input stream in, one valid-flagged copy per output port out.
interface demux_router_if #(
    parameter int DataWidth = 256,
    parameter int NumPorts  = 7
);
    logic [DataWidth-1:0] in_data;
    logic                 in_ready;
    logic [DataWidth-1:0] out_data [NumPorts];
    logic [NumPorts-1:0]  out_avail;

    modport master (output in_data, input in_ready, input out_data, output out_avail);
    modport slave  (input in_data, output in_ready, output out_data, input out_avail);
endinterface

// File: rtl/demux_router_route_table.sv
// Routing table RAM: one write port, one read-first read port with a holding output register.
module route_table
    import demux_pkg::*;
#(
    parameter int Depth     = 256,
    parameter int AddrWidth = 8,
    parameter int Width     = NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic                 re,
    input  logic [AddrWidth-1:0] raddr,
    output logic [Width-1:0]     q
);

    logic [Width-1:0] mem [Depth];

    // Contents are deliberately not reset; a same-address write/read returns the old entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/demux_router.sv
// Two-stage demux router: stage A accepts and looks up the port mask, stage B issues copies.
// Optional drop counter for zero-mask packets is enabled by DEMUX_DROP_COUNT_EN.
module demux_router
    import demux_pkg::*;
#(
    parameter int DataWidth        = DATA_WIDTH,
    parameter int IndexPos         = 128,
    parameter int NumPorts         = NUM_PORTS,
    parameter int RoutingTablesize = 256,
    parameter int AddrWidth        = 8
`ifdef DEMUX_DROP_COUNT_EN
    ,
    parameter int DropCntWidth     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_router_if.slave        bus,
    input  logic                 cfg_we,
    input  logic [AddrWidth-1:0] cfg_addr,
    input  logic [NumPorts-1:0]  cfg_mask,
    output logic                 busy
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [DropCntWidth-1:0] drop_count
`endif
);

    logic                  a_valid;
    logic [DataWidth-2:0]  a_payload;
    logic                  b_valid;
    logic [DataWidth-2:0]  b_payload;
    logic [NumPorts-1:0]   b_rem;
    logic [NumPorts-1:0]   rem_next;
    logic [NumPorts-1:0]   table_q;
    logic                  accept;
    logic                  a_adv;
    logic                  b_done;

    assign rem_next     = b_rem & ~bus.out_avail;
    assign b_done       = b_valid & (rem_next == '0);
    assign a_adv        = a_valid & (~b_valid | b_done);
    assign bus.in_ready = ~a_valid | a_adv;
    assign accept       = bus.in_ready & bus.in_data[DataWidth-1];
    assign busy         = a_valid | b_valid;

    route_table #(
        .Depth     (RoutingTablesize),
        .AddrWidth (AddrWidth),
        .Width     (NumPorts)
    ) u_route_table (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_mask),
        .re    (accept),
        .raddr (bus.in_data[IndexPos +: AddrWidth]),
        .q     (table_q)
    );

    // Stage A: holds one accepted packet while its mask is read from the table.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_payload <= '0;
        end else if (accept) begin
            a_valid   <= 1'b1;
            a_payload <= bus.in_data[DataWidth-2:0];
        end else if (a_adv) begin
            a_valid   <= 1'b0;
        end
    end

    // Stage B: the remaining-port mask shrinks as ports take their copy, so no port sees a duplicate.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid   <= 1'b0;
            b_payload <= '0;
            b_rem     <= '0;
        end else if (a_adv) begin
            b_valid   <= 1'b1;
            b_payload <= a_payload;
            b_rem     <= table_q;
        end else begin
            b_rem <= rem_next;
            if (b_done) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Copies are combinational so the downstream FIFO writes in the cycle it reports space.
    for (genvar i = 0; i < NumPorts; i++) begin : g_out
        assign bus.out_data[i] = {b_valid & b_rem[i] & bus.out_avail[i], b_payload};
    end

`ifdef DEMUX_DROP_COUNT_EN
    localparam logic [DropCntWidth-1:0] DropOne = 1;

    logic b_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_zero     <= 1'b0;
            drop_count <= '0;
        end else begin
            if (a_adv) begin
                b_zero <= (table_q == '0);
            end
            if (b_done && b_zero && (drop_count != '1)) begin
                drop_count <= drop_count + DropOne;
            end
        end
    end
`endif

endmodule
